// File: rtl/dmem_arbiter_if.sv
// Requester and dmem signal bundle for dmem_arbiter.
// Handshake: mN_req is valid and mN_gnt is ready. An access transfers in the cycle where both are high, and the requester holds wren/lock/addr/wdata stable until then.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_wren;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_wren;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  m0_req, m0_wren, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_wren, m1_lock, m1_addr, m1_wdata,
        input  mem_q,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_address, mem_data, mem_wren
    );

    modport master (
        output m0_req, m0_wren, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_wren, m1_lock, m1_addr, m1_wdata,
        output mem_q,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with a bounded lock, sharing one single-port synchronous dmem
// between two masters and steering each read result back to the master that issued it.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input logic          clock,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    logic       r_last;
    logic       r_locked;
    logic       r_owner;
    logic [7:0] r_lock_cnt;
    logic       r_rd_pend;
    logic       r_rd_id;

    logic              w_gnt_vld;
    logic              w_gnt_id;
    logic              w_sel_wren;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [7:0]        w_cnt_nxt;
    logic              w_owner_req;

    assign w_owner_req = r_owner ? bus.m1_req : bus.m0_req;

    // An asserted reset suppresses any grant immediately, before any clock edge arrives.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (reset) begin
            if (r_locked && w_owner_req) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = r_owner;
            end else if (bus.m0_req && bus.m1_req) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~r_last;
            end else if (bus.m0_req) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end else if (bus.m1_req) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
        end
    end

    assign w_sel_wren  = w_gnt_id ? bus.m1_wren  : bus.m0_wren;
    assign w_sel_lock  = w_gnt_id ? bus.m1_lock  : bus.m0_lock;
    assign w_sel_addr  = w_gnt_id ? bus.m1_addr  : bus.m0_addr;
    assign w_sel_wdata = w_gnt_id ? bus.m1_wdata : bus.m0_wdata;
    assign w_cnt_nxt   = r_lock_cnt + 8'd1;

    assign bus.m0_gnt      = w_gnt_vld && !w_gnt_id;
    assign bus.m1_gnt      = w_gnt_vld && w_gnt_id;
    assign bus.mem_wren    = w_gnt_vld && w_sel_wren;
    assign bus.mem_address = w_gnt_vld ? w_sel_addr  : '0;
    assign bus.mem_data    = w_gnt_vld ? w_sel_wdata : '0;

    assign bus.m0_rvalid = reset && r_rd_pend && !r_rd_id;
    assign bus.m1_rvalid = reset && r_rd_pend && r_rd_id;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_q : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_q : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last     <= 1'b1;
            r_locked   <= 1'b0;
            r_owner    <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_rd_pend  <= 1'b0;
            r_rd_id    <= 1'b0;
        end else begin
            if (w_gnt_vld) begin
                r_last <= w_gnt_id;
            end
            // The grant that brings the count to LOCK_MAX is the owner's last locked grant.
            if (w_gnt_vld && w_sel_lock && (w_cnt_nxt != 8'(LOCK_MAX))) begin
                r_locked   <= 1'b1;
                r_owner    <= w_gnt_id;
                r_lock_cnt <= w_cnt_nxt;
            end else begin
                r_locked   <= 1'b0;
                r_lock_cnt <= 8'd0;
            end
            r_rd_pend <= w_gnt_vld && !w_sel_wren;
            if (w_gnt_vld && !w_sel_wren) begin
                r_rd_id <= w_gnt_id;
            end
        end
    end
endmodule
